fft_pair_commutator: RTL and testbench
======================================

// Module: fft_pair_commutator
// PURPOSE
//   Streaming input commutator for a radix-2 butterfly stage. Accepts one complex
//   sample per valid cycle and buffers the first HALF_SIZE samples of each block.
//   It then pairs each later sample k+HALF_SIZE with buffered sample k, giving
//   (x[k], x[k+HALF_SIZE]) on the in0/in1 ports of the downstream butterfly.
// PARAMETERS
//   VIRTUAL_DATA_WIDTH  18  width of each signed real/imag component
//   HALF_SIZE           8   pair distance in samples; power of two, >= 2
// PORTS
//   clk          in   1                     clock, all state on rising edge
//   rst_n        in   1                     async active-low reset
//   sync_clear   in   1                     sync restart of block alignment
//   in_valid     in   1                     real_in/imag_in valid this cycle
//   real_in      in   VIRTUAL_DATA_WIDTH    signed sample, real part
//   imag_in      in   VIRTUAL_DATA_WIDTH    signed sample, imag part
//   pair_valid   out  1                     output pair valid (1-cycle pulse per pair)
//   real_out0    out  VIRTUAL_DATA_WIDTH    real part of x[k] (buffered)
//   imag_out0    out  VIRTUAL_DATA_WIDTH    imag part of x[k]
//   real_out1    out  VIRTUAL_DATA_WIDTH    real part of x[k+HALF_SIZE] (live)
//   imag_out1    out  VIRTUAL_DATA_WIDTH    imag part of x[k+HALF_SIZE]
//   pair_index   out  $clog2(HALF_SIZE)     k of the current pair
//   pair_first   out  1                     qualifies pair_valid, k == 0
//   pair_last    out  1                     qualifies pair_valid, k == HALF_SIZE-1
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=FILL, cnt=0, all outputs 0. Buffer contents
//     are don't-care and are not reset.
//   - State FILL: an accepted sample (in_valid=1) writes buf[cnt], then cnt++.
//     On accept with cnt==HALF_SIZE-1: cnt->0, state->PAIR.
//   - State PAIR: an accepted sample registers outputs on the same edge:
//     out0<=buf[cnt], out1<=input, pair_index<=cnt, pair_valid<=1,
//     pair_first<=(cnt==0), pair_last<=(cnt==HALF_SIZE-1); then cnt++.
//     On accept with cnt==HALF_SIZE-1: cnt->0, state->FILL.
//   - Latency: pair_valid rises in the cycle after sample k+HALF_SIZE is accepted.
//   - in_valid=0: state, cnt and buffer frozen; pair_valid<=0.
//     Data/index outputs hold their last values.
//   - pair_first/pair_last are registered with pair_valid and are 0 whenever
//     pair_valid is 0.
//   - No backpressure. The downstream stage must accept every pair_valid cycle.
//   - Back-to-back blocks: a sample accepted the cycle after the last PAIR accept
//     is written to buf[0]. There are no bubbles at block boundaries. Sustained
//     throughput is 1 sample/cycle, i.e. HALF_SIZE pairs per 2*HALF_SIZE cycles.
//   - Buffer read is combinational from the registered array. Write (FILL) and
//     read (PAIR) never occur in the same cycle.
//   - No arithmetic: data pass through bit-exact. No rounding, saturation or
//     sign change.
//   - sync_clear=1: next edge gives state=FILL, cnt=0, pair_valid=0,
//     pair_first=0, pair_last=0. Any sample presented that cycle is discarded
//     (clear wins over in_valid). Data outputs hold.
//   - Reset asserted mid-block discards the partial block. The first sample
//     accepted after release is treated as x[0] of a new block.
// TESTING (HALF_SIZE=4, VIRTUAL_DATA_WIDTH=18)
//   1. Continuous in_valid, real=k, imag=-k for k=0..7 -> pair_valid high in 4
//      consecutive cycles starting 1 cycle after k=4 is accepted. Pairs
//      (0,4),(1,5),(2,6),(3,7), e.g. out0=(0,0)/out1=(4,-4) first.
//      pair_first on (0,4), pair_last on (3,7).
//   2. Same stream with in_valid=0 on every other cycle -> identical pair
//      sequence. pair_valid is never high on consecutive cycles. Outputs hold
//      between pairs.
//   3. Two back-to-back blocks, real=0..15 -> pairs (0,4)..(3,7) then
//      (8,12)..(11,15). No lost samples and no bubble at the boundary.
//   4. sync_clear together with the 3rd sample, then stream 100..107 ->
//      clear-cycle sample is dropped. Pairs are (100,104)..(103,107).
//   5. Assert rst_n low for 1 cycle after the 6th sample (mid-PAIR) ->
//      immediate zero outputs. The next 8 samples 20..27 pair as (20,24)..(23,27).
//   6. Extreme values real=-131072, imag=131071 in x[0]; x[4]=(131071,-131072)
//      -> output bit-exact, with no sign or width corruption.

Source files
------------

// File: rtl/fft_pair_commutator.sv
// Input commutator for a radix-2 butterfly: buffers the first half of each
// block and pairs x[k] with x[k+HALF_SIZE] as the second half streams in.
module fft_pair_commutator #(
  parameter int VIRTUAL_DATA_WIDTH = 18,
  parameter int HALF_SIZE          = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 sync_clear,
  input  logic                                 in_valid,
  input  logic signed [VIRTUAL_DATA_WIDTH-1:0] real_in,
  input  logic signed [VIRTUAL_DATA_WIDTH-1:0] imag_in,
  output logic                                 pair_valid,
  output logic signed [VIRTUAL_DATA_WIDTH-1:0] real_out0,
  output logic signed [VIRTUAL_DATA_WIDTH-1:0] imag_out0,
  output logic signed [VIRTUAL_DATA_WIDTH-1:0] real_out1,
  output logic signed [VIRTUAL_DATA_WIDTH-1:0] imag_out1,
  output logic [$clog2(HALF_SIZE)-1:0]         pair_index,
  output logic                                 pair_first,
  output logic                                 pair_last
);

  localparam int W  = VIRTUAL_DATA_WIDTH;
  localparam int IW = $clog2(HALF_SIZE);

  typedef enum logic {FILL, PAIR} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic            pv_q, pv_d;
  logic            pf_q, pf_d;
  logic            pl_q, pl_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    r0_q, r0_d, i0_q, i0_d;
  logic [W-1:0]    r1_q, r1_d, i1_q, i1_d;
  logic [2*W-1:0]  mem_q [HALF_SIZE];
  logic            wr_en;
  logic            cnt_last;

  assign cnt_last = (cnt_q == IW'(HALF_SIZE - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pv_d    = 1'b0;
    pf_d    = 1'b0;
    pl_d    = 1'b0;
    idx_d   = idx_q;
    r0_d    = r0_q;
    i0_d    = i0_q;
    r1_d    = r1_q;
    i1_d    = i1_q;
    wr_en   = 1'b0;
    if (sync_clear) begin
      state_d = FILL;
      cnt_d   = '0;
    end else if (in_valid) begin
      cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
      if (state_q == FILL) begin
        wr_en = 1'b1;
        if (cnt_last) state_d = PAIR;
      end else begin
        {i0_d, r0_d} = mem_q[cnt_q];
        r1_d  = real_in;
        i1_d  = imag_in;
        idx_d = cnt_q;
        pv_d  = 1'b1;
        pf_d  = (cnt_q == '0);
        pl_d  = cnt_last;
        if (cnt_last) state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      pv_q    <= 1'b0;
      pf_q    <= 1'b0;
      pl_q    <= 1'b0;
      idx_q   <= '0;
      r0_q    <= '0;
      i0_q    <= '0;
      r1_q    <= '0;
      i1_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      pf_q    <= pf_d;
      pl_q    <= pl_d;
      idx_q   <= idx_d;
      r0_q    <= r0_d;
      i0_q    <= i0_d;
      r1_q    <= r1_d;
      i1_q    <= i1_d;
    end
  end

  // Sample storage is intentionally left unreset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[cnt_q] <= {imag_in, real_in};
  end

  assign pair_valid = pv_q;
  assign pair_first = pf_q;
  assign pair_last  = pl_q;
  assign pair_index = idx_q;
  assign real_out0  = r0_q;
  assign imag_out0  = i0_q;
  assign real_out1  = r1_q;
  assign imag_out1  = i1_q;

endmodule

// File: tb/tb_fft_pair_commutator.sv
// Bench for fft_pair_commutator: expected pairs are queued from the known
// stimulus and checked by a monitor whenever pair_valid is seen.
module tb_fft_pair_commutator;

  localparam int W  = 18;
  localparam int HS = 4;

  typedef struct {
    logic signed [W-1:0] r0, i0, r1, i1;
    logic [1:0]          idx;
    logic                f, l;
  } exp_t;

  logic                clk, rst_n, sync_clear, in_valid;
  logic signed [W-1:0] real_in, imag_in;
  logic                pair_valid, pair_first, pair_last;
  logic signed [W-1:0] real_out0, imag_out0, real_out1, imag_out1;
  logic [1:0]          pair_index;

  int   checks = 0;
  int   errors = 0;
  int   pairs_seen = 0;
  int   consec = 0;
  logic prev_pv = 1'b0;
  exp_t sb[$];

  fft_pair_commutator #(.VIRTUAL_DATA_WIDTH(W), .HALF_SIZE(HS)) dut (
    .clk(clk), .rst_n(rst_n), .sync_clear(sync_clear),
    .in_valid(in_valid), .real_in(real_in), .imag_in(imag_in),
    .pair_valid(pair_valid),
    .real_out0(real_out0), .imag_out0(imag_out0),
    .real_out1(real_out1), .imag_out1(imag_out1),
    .pair_index(pair_index), .pair_first(pair_first), .pair_last(pair_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pair_valid) begin
        pairs_seen++;
        if (prev_pv) consec++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pair: got r0=%0d r1=%0d, required no pair",
                   real_out0, real_out1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (real_out0 !== e.r0 || imag_out0 !== e.i0 ||
              real_out1 !== e.r1 || imag_out1 !== e.i1 ||
              pair_index !== e.idx || pair_first !== e.f ||
              pair_last !== e.l) begin
            errors++;
            $display("FAIL pair: got (%0d,%0d)/(%0d,%0d) k=%0d f=%b l=%b, required (%0d,%0d)/(%0d,%0d) k=%0d f=%b l=%b",
                     real_out0, imag_out0, real_out1, imag_out1,
                     pair_index, pair_first, pair_last,
                     e.r0, e.i0, e.r1, e.i1, e.idx, e.f, e.l);
          end
        end
      end else begin
        checks++;
        if (pair_first !== 1'b0 || pair_last !== 1'b0) begin
          errors++;
          $display("FAIL flags_idle: got first=%b last=%b, required 0 0",
                   pair_first, pair_last);
        end
      end
    end
    prev_pv = pair_valid;
  end

  task automatic push(input int r0, input int i0, input int r1,
                      input int i1, input int k);
    exp_t e;
    e.r0  = W'(r0);
    e.i0  = W'(i0);
    e.r1  = W'(r1);
    e.i1  = W'(i1);
    e.idx = 2'(k);
    e.f   = (k == 0);
    e.l   = (k == HS - 1);
    sb.push_back(e);
  endtask

  task automatic step(input logic v, input int r, input int i,
                      input logic clr = 1'b0);
    in_valid   = v;
    real_in    = W'(r);
    imag_in    = W'(i);
    sync_clear = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 0, 0);
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (pair_valid !== 1'b0 || pair_first !== 1'b0 || pair_last !== 1'b0 ||
        pair_index !== 2'd0 || real_out0 !== '0 || imag_out0 !== '0 ||
        real_out1 !== '0 || imag_out1 !== '0) begin
      errors++;
      $display("FAIL %s: got pv=%b r0=%0d i0=%0d r1=%0d i1=%0d k=%0d, required all 0",
               name, pair_valid, real_out0, imag_out0, real_out1, imag_out1,
               pair_index);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; sync_clear = 1'b0;
    real_in = '0; imag_in = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    rst_n = 1'b1;
    idle(2);
    check_zero_outputs("after_release");
  endtask

  task automatic test_continuous();
    int p0, c0;
    p0 = pairs_seen; c0 = consec;
    for (int k = 0; k < 8; k++) begin
      if (k >= HS) push(k - HS, -(k - HS), k, -k, k - HS);
      step(1'b1, k, -k);
      if (k == 3) check_int("cont_no_early_pair", int'(pair_valid), 0);
      if (k == 4) check_int("cont_latency", int'(pair_valid), 1);
    end
    idle(3);
    check_int("cont_pairs", pairs_seen - p0, 4);
    check_int("cont_consecutive", consec - c0, 3);
    check_int("cont_sb_empty", sb.size(), 0);
  endtask

  task automatic test_gapped();
    int p0, c0;
    p0 = pairs_seen; c0 = consec;
    for (int k = 0; k < 8; k++) begin
      if (k >= HS) push(k - HS, -(k - HS), k, -k, k - HS);
      step(1'b1, k, -k);
      step(1'b0, 999, 999);
      if (k == 5) begin
        check_int("gap_pv_low", int'(pair_valid), 0);
        check_int("gap_hold_r1", int'(real_out1), 5);
        check_int("gap_hold_r0", int'(real_out0), 1);
      end
    end
    idle(2);
    check_int("gap_pairs", pairs_seen - p0, 4);
    check_int("gap_consecutive", consec - c0, 0);
    check_int("gap_sb_empty", sb.size(), 0);
  endtask

  task automatic test_back_to_back();
    int p0, c0;
    p0 = pairs_seen; c0 = consec;
    for (int k = 0; k < 16; k++) begin
      if ((k % 8) >= HS) push(k - HS, -(k - HS), k, -k, (k % 8) - HS);
      step(1'b1, k, -k);
      if (k == 12) check_int("b2b_second_latency", int'(pair_valid), 1);
    end
    idle(3);
    check_int("b2b_pairs", pairs_seen - p0, 8);
    check_int("b2b_consecutive", consec - c0, 6);
    check_int("b2b_sb_empty", sb.size(), 0);
  endtask

  task automatic test_sync_clear();
    step(1'b1, 0, 0);
    step(1'b1, 1, 1);
    step(1'b1, 2, 2, 1'b1);
    check_int("clr_pv_low", int'(pair_valid), 0);
    check_int("clr_hold_r1", int'(real_out1), 15);
    for (int k = 0; k < 8; k++) begin
      if (k >= HS) push(100 + k - HS, -(100 + k - HS), 100 + k, -(100 + k), k - HS);
      step(1'b1, 100 + k, -(100 + k));
    end
    idle(3);
    check_int("clr_sb_empty", sb.size(), 0);
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 6; k++) begin
      if (k >= HS) push(50 + k - HS, 0, 50 + k, 0, k - HS);
      step(1'b1, 50 + k, 0);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k >= HS) push(20 + k - HS, -(20 + k - HS), 20 + k, -(20 + k), k - HS);
      step(1'b1, 20 + k, -(20 + k));
    end
    idle(3);
    check_int("rst_sb_empty", sb.size(), 0);
  endtask

  task automatic test_extremes();
    push(-131072, 131071, 131071, -131072, 0);
    push(7, -7, -1, 1, 1);
    push(-3, 3, 65535, -65536, 2);
    push(0, 0, -131072, -131072, 3);
    step(1'b1, -131072, 131071);
    step(1'b1, 7, -7);
    step(1'b1, -3, 3);
    step(1'b1, 0, 0);
    step(1'b1, 131071, -131072);
    check_int("ext_r0", int'(real_out0), -131072);
    check_int("ext_i1", int'(imag_out1), -131072);
    step(1'b1, -1, 1);
    step(1'b1, 65535, -65536);
    step(1'b1, -131072, -131072);
    idle(3);
    check_int("ext_sb_empty", sb.size(), 0);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gapped();
    test_back_to_back();
    test_sync_clear();
    test_mid_reset();
    test_extremes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
